// File: rtl/score_display_pkg.sv
// ---------------------------------------------------------------------------
// score_display_pkg
// Shared types and constants for the score display slice:
//   - conv_state_e : state encoding of the sequential binary-to-BCD converter
//   - SEG_*        : active-low seven-segment patterns, bit order gfedcba
//   - seg_encode   : maps a BCD nibble to its segment pattern (blank if > 9)
// ---------------------------------------------------------------------------
package score_display_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } conv_state_e;

   localparam int BIN_W   = 9;
   localparam int BCD_W   = 12;
   localparam int SHREG_W = BIN_W + BCD_W;

   localparam logic [6:0] SEG_0     = 7'b1000000;
   localparam logic [6:0] SEG_1     = 7'b1111001;
   localparam logic [6:0] SEG_2     = 7'b0100100;
   localparam logic [6:0] SEG_3     = 7'b0110000;
   localparam logic [6:0] SEG_4     = 7'b0011001;
   localparam logic [6:0] SEG_5     = 7'b0010010;
   localparam logic [6:0] SEG_6     = 7'b0000010;
   localparam logic [6:0] SEG_7     = 7'b1111000;
   localparam logic [6:0] SEG_8     = 7'b0000000;
   localparam logic [6:0] SEG_9     = 7'b0010000;
   localparam logic [6:0] SEG_BLANK = 7'b1111111;

   // Non-decimal nibbles cannot come out of the converter, but map them
   // to blank so a corrupted digit never lights a misleading pattern.
   function automatic logic [6:0] seg_encode(input logic [3:0] nibble);
      logic [6:0] seg;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_BLANK;
      endcase
      return seg;
   endfunction

endpackage

// File: rtl/score_display_bin2bcd_seq.sv
// ---------------------------------------------------------------------------
// bin2bcd_seq
// Sequential double-dabble converter: 9-bit binary to three BCD nibbles,
// one shift per clock, nine shifts per conversion.
// Ports:
//   i_clk, i_rst       clock, synchronous active-high reset
//   i_start            start a conversion (honoured only while o_ready)
//   i_bin[8:0]         binary value captured on the start edge
//   o_ready            converter is idle and can accept i_start
//   o_done             one-cycle strobe; o_hund/o_tens/o_ones are final
//   o_hund/tens/ones   BCD result nibbles
// ---------------------------------------------------------------------------
module bin2bcd_seq
   import score_display_pkg::*;
(
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_start,
   input  logic [BIN_W-1:0] i_bin,
   output logic             o_ready,
   output logic             o_done,
   output logic [3:0]       o_hund,
   output logic [3:0]       o_tens,
   output logic [3:0]       o_ones
);

   conv_state_e        state_q, state_d;
   logic [SHREG_W-1:0] shreg_q, shreg_d;
   logic [3:0]         bitcnt_q, bitcnt_d;
   logic [SHREG_W-1:0] adj;

   // Double-dabble correction: any BCD nibble of 5 or more gets +3 so that
   // the following left shift carries correctly into the next decade.
   always_comb begin
      adj = shreg_q;
      if (shreg_q[20:17] >= 4'd5) adj[20:17] = shreg_q[20:17] + 4'd3;
      if (shreg_q[16:13] >= 4'd5) adj[16:13] = shreg_q[16:13] + 4'd3;
      if (shreg_q[12:9]  >= 4'd5) adj[12:9]  = shreg_q[12:9]  + 4'd3;
   end

   // Converter FSM: load on start, nine correct-and-shift steps, then a
   // single DONE cycle during which the parent commits the result.
   always_comb begin
      state_d  = state_q;
      shreg_d  = shreg_q;
      bitcnt_d = bitcnt_q;
      case (state_q)
         IDLE: begin
            if (i_start) begin
               shreg_d  = {{BCD_W{1'b0}}, i_bin};
               bitcnt_d = 4'd0;
               state_d  = SHIFT;
            end
         end
         SHIFT: begin
            shreg_d  = adj << 1;
            bitcnt_d = bitcnt_q + 4'd1;
            if (bitcnt_q == 4'd8) state_d = DONE;
         end
         DONE: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q  <= IDLE;
         shreg_q  <= '0;
         bitcnt_q <= 4'd0;
      end else begin
         state_q  <= state_d;
         shreg_q  <= shreg_d;
         bitcnt_q <= bitcnt_d;
      end
   end

   assign o_ready = (state_q == IDLE);
   assign o_done  = (state_q == DONE);
   assign o_hund  = shreg_q[20:17];
   assign o_tens  = shreg_q[16:13];
   assign o_ones  = shreg_q[12:9];

endmodule

// File: rtl/score_display.sv
// ---------------------------------------------------------------------------
// score_display
// Shows the 9-bit game score on a 4-digit active-low seven-segment display
// with leading-zero suppression, and blinks the whole display while the
// game-over flag is high.
// Ports:
//   i_clk, i_rst   100 MHz clock, synchronous active-high reset
//   i_score[8:0]   binary score 0..511
//   i_endgame      game-over flag; display blinks while high
//   o_an[3:0]      digit anodes, active-low, bit 0 = ones digit
//   o_seg[6:0]     segments gfedcba, active-low
//   o_dp           decimal point, active-low, always off
// Parameters:
//   REFRESH_DIV    clock cycles each digit stays lit
//   BLINK_DIV      clock cycles per blink half-period
// ---------------------------------------------------------------------------
module score_display
   import score_display_pkg::*;
#(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 25000000
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [BIN_W-1:0] i_score,
   input  logic             i_endgame,
   output logic [3:0]       o_an,
   output logic [6:0]       o_seg,
   output logic             o_dp
);

   localparam int REF_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

   logic [BIN_W-1:0] r_last_q, r_last_d;
   logic [3:0]       d2_q, d2_d, d1_q, d1_d, d0_q, d0_d;
   logic [REF_W-1:0] refcnt_q, refcnt_d;
   logic [1:0]       idx_q, idx_d;
   logic [BLK_W-1:0] blkcnt_q, blkcnt_d;
   logic             phase_q, phase_d;
   logic [3:0]       an_q, an_d;
   logic [6:0]       seg_q, seg_d;

   logic             conv_ready, conv_done, conv_start;
   logic [3:0]       conv_hund, conv_tens, conv_ones;
   logic             blank_hund, blank_tens;

   // A change is only picked up while the converter is idle; r_last keeps
   // the last value handed over, so a change made mid-conversion is still
   // seen as a mismatch afterwards and converted automatically.
   assign conv_start = conv_ready && (i_score != r_last_q);

   bin2bcd_seq u_bin2bcd (
      .i_clk   (i_clk),
      .i_rst   (i_rst),
      .i_start (conv_start),
      .i_bin   (i_score),
      .o_ready (conv_ready),
      .o_done  (conv_done),
      .o_hund  (conv_hund),
      .o_tens  (conv_tens),
      .o_ones  (conv_ones)
   );

   // Digit registers update only on the converter's done strobe, so the
   // display never shows a half-shifted BCD value.
   always_comb begin
      r_last_d = r_last_q;
      d2_d     = d2_q;
      d1_d     = d1_q;
      d0_d     = d0_q;
      if (conv_start) r_last_d = i_score;
      if (conv_done) begin
         d2_d = conv_hund;
         d1_d = conv_tens;
         d0_d = conv_ones;
      end
   end

   // Refresh timer: each digit stays selected for REFRESH_DIV cycles.
   always_comb begin
      refcnt_d = refcnt_q + REF_W'(1);
      idx_d    = idx_q;
      if (refcnt_q == REF_W'(REFRESH_DIV - 1)) begin
         refcnt_d = '0;
         idx_d    = idx_q + 2'd1;
      end
   end

   // Blink timer runs only while endgame is high and is held cleared
   // otherwise, so every blink burst starts in the visible phase.
   always_comb begin
      blkcnt_d = '0;
      phase_d  = 1'b0;
      if (i_endgame) begin
         blkcnt_d = blkcnt_q + BLK_W'(1);
         phase_d  = phase_q;
         if (blkcnt_q == BLK_W'(BLINK_DIV - 1)) begin
            blkcnt_d = '0;
            phase_d  = ~phase_q;
         end
      end
   end

   // Output stage: select the current digit, apply leading-zero blanking
   // and blinking. Gating phase with the live endgame input makes the
   // display reappear on the very next output update when endgame drops.
   always_comb begin
      blank_hund = (d2_q == 4'd0);
      blank_tens = blank_hund && (d1_q == 4'd0);
      case (idx_q)
         2'd0:    seg_d = seg_encode(d0_q);
         2'd1:    seg_d = blank_tens ? SEG_BLANK : seg_encode(d1_q);
         2'd2:    seg_d = blank_hund ? SEG_BLANK : seg_encode(d2_q);
         default: seg_d = SEG_BLANK;
      endcase
      an_d = ~(4'b0001 << idx_q);
      if (i_endgame && phase_q) an_d = 4'b1111;
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_last_q <= '0;
         d2_q     <= 4'd0;
         d1_q     <= 4'd0;
         d0_q     <= 4'd0;
         refcnt_q <= '0;
         idx_q    <= 2'd0;
         blkcnt_q <= '0;
         phase_q  <= 1'b0;
         an_q     <= 4'b1111;
         seg_q    <= SEG_BLANK;
      end else begin
         r_last_q <= r_last_d;
         d2_q     <= d2_d;
         d1_q     <= d1_d;
         d0_q     <= d0_d;
         refcnt_q <= refcnt_d;
         idx_q    <= idx_d;
         blkcnt_q <= blkcnt_d;
         phase_q  <= phase_d;
         an_q     <= an_d;
         seg_q    <= seg_d;
      end
   end

   assign o_an  = an_q;
   assign o_seg = seg_q;
   assign o_dp  = 1'b1;

endmodule
